notch_sched: RTL and testbench

Per-sample sequencer for the adaptive notch canceller datapath. It time-shares a single registered multiplier across NTAP weight×reference products. It then strobes the accumulator, the error stage and the weight-update stage in order. It sits between the sample-rate input strobe and the datapath registers, replacing free-running modulo counters with an explicit valid/ready handshake.

---
 rtl/notch_pkg.sv | 29 ++
 rtl/notch_sched_dly.sv | 34 +++
 rtl/notch_sched.sv | 174 +++++++++++++++++
 tb/tb_notch_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/notch_pkg.sv
// Shared types and defaults for the notch canceller sample sequencer.
package notch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    DRAIN = 3'd2,
    ERR   = 3'd3,
    UPD   = 3'd4
  } state_e;

  localparam int unsigned NTAP_DEF     = 4;
  localparam int unsigned MULT_LAT_DEF = 1;
  localparam int unsigned SAMPLE_LAT   = NTAP_DEF + MULT_LAT_DEF + 2;

  // Drain counter only has to reach MULT_LAT-1 (MULT_LAT <= 3)
  localparam int unsigned DRAIN_W = 2;

  // Accumulator control carried alongside the multiplier pipeline
  typedef struct packed {
    logic en;
    logic clr;
  } acc_ctl_t;

  function automatic int unsigned sample_lat(input int unsigned ntap, input int unsigned mult_lat);
    return ntap + mult_lat + 2;
  endfunction

endpackage

// File: rtl/notch_sched_dly.sv
// Shift register aligning accumulator enable/clear with the shared multiplier output.
module notch_sched_dly
  import notch_pkg::*;
#(
  parameter int unsigned DEPTH = MULT_LAT_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  acc_ctl_t din,
  output acc_ctl_t dout
);

  acc_ctl_t [DEPTH-1:0] pipe_q;
  acc_ctl_t [DEPTH-1:0] pipe_d;

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = din;
    for (int i = 1; i < int'(DEPTH); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/notch_sched.sv
// Per-sample sequencer time-sharing one multiplier across NTAP taps, then strobing acc/err/update.
// Optional NOTCH_SCHED_STATS_EN adds drop_cnt and upd_cnt statistics outputs.
module notch_sched
  import notch_pkg::*;
#(
  parameter int unsigned NTAP     = NTAP_DEF,
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned SEL_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             freeze,
  input  logic             ovr_clr,
  output logic [SEL_W-1:0] tap_sel,
  output logic             mult_en,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             err_en,
  output logic             w_upd_en,
  output logic             dout_valid,
  output logic             busy,
  output logic             overrun
`ifdef NOTCH_SCHED_STATS_EN
  ,
  output logic [7:0]       drop_cnt,
  output logic [15:0]      upd_cnt
`endif
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   tap_q, tap_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               mult_en_q, mult_en_d;
  logic               err_en_q, err_en_d;
  logic               w_upd_en_q, w_upd_en_d;
  logic               dout_valid_q, dout_valid_d;
  logic               busy_q, busy_d;
  logic               din_ready_q, din_ready_d;
  logic               overrun_q, overrun_d;
  logic               din_valid_q;
  logic               accept;
  logic               drop;
  logic               last_tap;
  logic               last_drain;
  acc_ctl_t           acc_in;
  acc_ctl_t           acc_out;

  // A held din_valid while not ready is a stall; a fresh assertion while not ready is a drop
  assign accept     = din_valid & din_ready_q;
  assign drop       = din_valid & ~din_ready_q & ~din_valid_q;
  assign last_tap   = (tap_q == SEL_W'(NTAP - 1));
  assign last_drain = (drain_q == DRAIN_W'(MULT_LAT - 1));

  always_comb begin
    state_d = state_q;
    tap_d   = '0;
    drain_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = MUL;
      end
      MUL: begin
        if (last_tap) state_d = DRAIN;
        else          tap_d   = tap_q + SEL_W'(1);
      end
      DRAIN: begin
        if (last_drain) state_d = ERR;
        else            drain_d = drain_q + DRAIN_W'(1);
      end
      ERR: begin
        state_d = UPD;
      end
      UPD: begin
        state_d = accept ? MUL : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they are registered alongside it
    mult_en_d    = (state_d == MUL);
    err_en_d     = (state_d == ERR);
    dout_valid_d = (state_d == UPD);
    w_upd_en_d   = (state_d == UPD) & ~freeze;
    busy_d       = (state_d != IDLE);
    din_ready_d  = (state_d == IDLE) | (state_d == UPD);
    overrun_d    = drop | (overrun_q & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tap_q        <= '0;
      drain_q      <= '0;
      mult_en_q    <= 1'b0;
      err_en_q     <= 1'b0;
      w_upd_en_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      din_ready_q  <= 1'b0;
      overrun_q    <= 1'b0;
      din_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      drain_q      <= drain_d;
      mult_en_q    <= mult_en_d;
      err_en_q     <= err_en_d;
      w_upd_en_q   <= w_upd_en_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      din_ready_q  <= din_ready_d;
      overrun_q    <= overrun_d;
      din_valid_q  <= din_valid;
    end
  end

  // Accumulator strobes ride the same pipeline depth as the multiplier
  assign acc_in.en  = mult_en_q;
  assign acc_in.clr = mult_en_q & (tap_q == '0);

  notch_sched_dly #(
    .DEPTH (MULT_LAT)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (acc_in),
    .dout  (acc_out)
  );

  assign din_ready  = din_ready_q;
  assign tap_sel    = tap_q;
  assign mult_en    = mult_en_q;
  assign acc_clr    = acc_out.clr;
  assign acc_en     = acc_out.en;
  assign err_en     = err_en_q;
  assign w_upd_en   = w_upd_en_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

`ifdef NOTCH_SCHED_STATS_EN
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic [15:0] upd_cnt_q, upd_cnt_d;

  // Drop counter saturates; a drop coinciding with a clear is kept, like overrun
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovr_clr) begin
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    upd_cnt_d = upd_cnt_q + (w_upd_en_q ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      upd_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      upd_cnt_q  <= upd_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign upd_cnt  = upd_cnt_q;
`endif

endmodule

// File: tb/tb_notch_sched.sv
// Directed bench for notch_sched: per-cycle vector table plus reset, alternate-config and stats sequences.
module tb_notch_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_valid, din_valid2, freeze, ovr_clr;

  logic       din_ready, mult_en, acc_clr, acc_en, err_en, w_upd_en, dout_valid, busy, overrun;
  logic [1:0] tap_sel;
  logic       din_ready_2, mult_en_2, acc_clr_2, acc_en_2, err_en_2, w_upd_en_2, dout_valid_2, busy_2, overrun_2;
  logic [0:0] tap_sel_2;
`ifdef NOTCH_SCHED_STATS_EN
  logic [7:0]  drop_cnt, drop_cnt_2;
  logic [15:0] upd_cnt, upd_cnt_2;
`endif

  always #5 clk = ~clk;

  notch_sched #(.NTAP(4), .MULT_LAT(1), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready),
    .freeze(freeze), .ovr_clr(ovr_clr), .tap_sel(tap_sel), .mult_en(mult_en),
    .acc_clr(acc_clr), .acc_en(acc_en), .err_en(err_en), .w_upd_en(w_upd_en),
    .dout_valid(dout_valid), .busy(busy), .overrun(overrun)
`ifdef NOTCH_SCHED_STATS_EN
    , .drop_cnt(drop_cnt), .upd_cnt(upd_cnt)
`endif
  );

  notch_sched #(.NTAP(2), .MULT_LAT(3), .SEL_W(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid2), .din_ready(din_ready_2),
    .freeze(freeze), .ovr_clr(ovr_clr), .tap_sel(tap_sel_2), .mult_en(mult_en_2),
    .acc_clr(acc_clr_2), .acc_en(acc_en_2), .err_en(err_en_2), .w_upd_en(w_upd_en_2),
    .dout_valid(dout_valid_2), .busy(busy_2), .overrun(overrun_2)
`ifdef NOTCH_SCHED_STATS_EN
    , .drop_cnt(drop_cnt_2), .upd_cnt(upd_cnt_2)
`endif
  );

  // Observed vector: {tap_sel, mult_en, acc_clr, acc_en, err_en, w_upd_en, dout_valid, busy, din_ready, overrun}
  logic [10:0] obs1;
  assign obs1 = {tap_sel, mult_en, acc_clr, acc_en, err_en, w_upd_en, dout_valid, busy, din_ready, overrun};

  typedef struct packed {
    logic        dv;
    logic        fr;
    logic        oc;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [10:0] ex(input logic [1:0] tap,
                                     input logic m, c, a, e, w, d, b, r, ov);
    return {tap, m, c, a, e, w, d, b, r, ov};
  endfunction

  task automatic add(input logic dv, input logic fr, input logic oc, input logic [10:0] ev);
    vec_t v;
    v.dv  = dv;
    v.fr  = fr;
    v.oc  = oc;
    v.exp = ev;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] p_tap, p_m, p_c, p_a, p_e, p_d;
    logic [4:0] exp2, act2;

    rst_n = 1'b0; din_valid = 1'b0; din_valid2 = 1'b0; freeze = 1'b0; ovr_clr = 1'b0;

    // Row k: inputs driven during cycle k, outputs expected in cycle k+1
    // Single sample
    add(1,0,0, ex(0,1,0,0,0,0,0,1,0,0));
    add(0,0,0, ex(1,1,1,1,0,0,0,1,0,0));
    add(0,0,0, ex(2,1,0,1,0,0,0,1,0,0));
    add(0,0,0, ex(3,1,0,1,0,0,0,1,0,0));
    add(0,0,0, ex(0,0,0,1,0,0,0,1,0,0));
    add(0,0,0, ex(0,0,0,0,1,0,0,1,0,0));
    add(0,0,0, ex(0,0,0,0,0,1,1,1,1,0));
    add(0,0,0, ex(0,0,0,0,0,0,0,0,1,0));
    // Overrun: second offer at cycle 3 dropped, cleared by ovr_clr at 10
    add(1,0,0, ex(0,1,0,0,0,0,0,1,0,0));
    add(0,0,0, ex(1,1,1,1,0,0,0,1,0,0));
    add(0,0,0, ex(2,1,0,1,0,0,0,1,0,0));
    add(1,0,0, ex(3,1,0,1,0,0,0,1,0,1));
    add(0,0,0, ex(0,0,0,1,0,0,0,1,0,1));
    add(0,0,0, ex(0,0,0,0,1,0,0,1,0,1));
    add(0,0,0, ex(0,0,0,0,0,1,1,1,1,1));
    add(0,0,0, ex(0,0,0,0,0,0,0,0,1,1));
    add(0,0,0, ex(0,0,0,0,0,0,0,0,1,1));
    add(0,0,0, ex(0,0,0,0,0,0,0,0,1,1));
    add(0,0,1, ex(0,0,0,0,0,0,0,0,1,0));
    // Freeze around UPD, plus drop coinciding with ovr_clr (set wins)
    add(1,0,0, ex(0,1,0,0,0,0,0,1,0,0));
    add(0,0,0, ex(1,1,1,1,0,0,0,1,0,0));
    add(0,0,0, ex(2,1,0,1,0,0,0,1,0,0));
    add(1,0,1, ex(3,1,0,1,0,0,0,1,0,1));
    add(0,0,0, ex(0,0,0,1,0,0,0,1,0,1));
    add(0,1,0, ex(0,0,0,0,1,0,0,1,0,1));
    add(0,1,0, ex(0,0,0,0,0,0,1,1,1,1));
    add(0,1,1, ex(0,0,0,0,0,0,0,0,1,0));
    // Freeze only during MUL: update still enabled
    add(1,0,0, ex(0,1,0,0,0,0,0,1,0,0));
    add(0,1,0, ex(1,1,1,1,0,0,0,1,0,0));
    add(0,1,0, ex(2,1,0,1,0,0,0,1,0,0));
    add(0,1,0, ex(3,1,0,1,0,0,0,1,0,0));
    add(0,0,0, ex(0,0,0,1,0,0,0,1,0,0));
    add(0,0,0, ex(0,0,0,0,1,0,0,1,0,0));
    add(0,0,0, ex(0,0,0,0,0,1,1,1,1,0));
    add(0,0,0, ex(0,0,0,0,0,0,0,0,1,0));
    // Back-to-back: held din_valid stalls, accepted again in UPD, no overrun
    add(1,0,0, ex(0,1,0,0,0,0,0,1,0,0));
    add(1,0,0, ex(1,1,1,1,0,0,0,1,0,0));
    add(1,0,0, ex(2,1,0,1,0,0,0,1,0,0));
    add(1,0,0, ex(3,1,0,1,0,0,0,1,0,0));
    add(1,0,0, ex(0,0,0,1,0,0,0,1,0,0));
    add(1,0,0, ex(0,0,0,0,1,0,0,1,0,0));
    add(1,0,0, ex(0,0,0,0,0,1,1,1,1,0));
    add(1,0,0, ex(0,1,0,0,0,0,0,1,0,0));
    add(1,0,0, ex(1,1,1,1,0,0,0,1,0,0));
    add(0,0,0, ex(2,1,0,1,0,0,0,1,0,0));
    add(0,0,0, ex(3,1,0,1,0,0,0,1,0,0));
    add(0,0,0, ex(0,0,0,1,0,0,0,1,0,0));
    add(0,0,0, ex(0,0,0,0,1,0,0,1,0,0));
    add(0,0,0, ex(0,0,0,0,0,1,1,1,1,0));
    add(0,0,0, ex(0,0,0,0,0,0,0,0,1,0));

    #1;
    check("reset_state", 32'(obs1), 32'd0);
    step();
    step();
    check("reset_held", 32'(obs1), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_after_reset", 32'(obs1), 32'(ex(0,0,0,0,0,0,0,0,1,0)));

    foreach (vecs[i]) begin
      din_valid = vecs[i].dv;
      freeze    = vecs[i].fr;
      ovr_clr   = vecs[i].oc;
      step();
      check($sformatf("vec%0d", i), 32'(obs1), 32'(vecs[i].exp));
    end
    din_valid = 1'b0; freeze = 1'b0; ovr_clr = 1'b0;
    step();

    // Asynchronous reset in the middle of MUL
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_sample", 32'(obs1), 32'd0);
    step();
    check("reset_no_partial", 32'(obs1), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_after_mid_reset", 32'(obs1), 32'(ex(0,0,0,0,0,0,0,0,1,0)));
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    check("restart_tap0", 32'(obs1), 32'(ex(0,1,0,0,0,0,0,1,0,0)));
    step();
    check("restart_tap1", 32'(obs1), 32'(ex(1,1,1,1,0,0,0,1,0,0)));
    repeat (8) step();

    // NTAP=2, MULT_LAT=3 instance: expected strobe positions per cycle after accept
    p_tap = 9'b000000100;
    p_m   = 9'b000000110;
    p_c   = 9'b000010000;
    p_a   = 9'b000110000;
    p_e   = 9'b001000000;
    p_d   = 9'b010000000;
    din_valid2 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      din_valid2 = 1'b0;
      exp2 = {p_m[c], p_c[c], p_a[c], p_e[c], p_d[c]};
      act2 = {mult_en_2, acc_clr_2, acc_en_2, err_en_2, dout_valid_2};
      check($sformatf("cfg2_cycle%0d_strobes", c), 32'(act2), 32'(exp2));
      check($sformatf("cfg2_cycle%0d_tap", c), 32'(tap_sel_2), 32'(p_tap[c]));
    end
    check("cfg2_wupd_at_7_absent_at_8", 32'(w_upd_en_2), 32'd0);

    // Repeated fresh offers while busy: many drops on the second instance
    for (int k = 0; k < 1000; k++) begin
      din_valid2 = (k % 2 == 0);
      step();
    end
    din_valid2 = 1'b0;
    repeat (10) step();
    check("cfg2_overrun_after_drops", 32'(overrun_2), 32'd1);
    check("cfg1_overrun_untouched", 32'(overrun), 32'd0);
`ifdef NOTCH_SCHED_STATS_EN
    check("drop_cnt_saturated", 32'(drop_cnt_2), 32'd255);
    check("drop_cnt_cfg1_zero", 32'(drop_cnt), 32'd0);
`endif
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("cfg2_overrun_cleared", 32'(overrun_2), 32'd0);
`ifdef NOTCH_SCHED_STATS_EN
    check("drop_cnt_cleared", 32'(drop_cnt_2), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
